// File: rtl/ahb_lcd_fifo_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the LCD FIFO controller.
// Single clock domain; the slave never inserts wait states.
interface ahb_lcd_fifo_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb_lcd_fifo_ctrl.sv
// AHB-Lite HD44780 LCD writer: posted CMD/DATA bytes queue in a FIFO and a timed E-strobe engine drains it.
// Write->E rise in 2+SETUP_CYC cycles when idle; no wait states, pushes to a full FIFO drop and set ovf. LCD_IRQ_EN adds LCD_IRQ.
module ahb_lcd_fifo_ctrl #(
  parameter int LCD_DW     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SETUP_CYC  = 5,
  parameter int E_HIGH_CYC = 75,
  parameter int HOLD_CYC   = 5,
  parameter int GAP_CYC    = 2500,
  parameter int LONG_CYC   = 80000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_lcd_fifo_ctrl_if.slave ahb,
  output logic [LCD_DW-1:0] LCD_DATA,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic              LCD_E
`ifdef LCD_IRQ_EN
  ,
  output logic              LCD_IRQ
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_GAP} state_t;

  typedef struct packed {
    logic       rs;
    logic       raw;
    logic [7:0] dat;
  } entry_t;

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int M1   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int M2   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int M3   = (M1 > M2) ? M1 : M2;
  localparam int MAXC = (M3 > LONG_CYC) ? M3 : LONG_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  // Timer counts down to zero, so each load is the cycle count minus one.
  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] T_EHIGH = TW'(E_HIGH_CYC - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] T_LONG  = TW'(LONG_CYC - 1);

  logic        ap_vld;
  logic        ap_wr;
  logic [1:0]  ap_addr;

  logic        wr_cmd, wr_dat, wr_stat, wr_ctrl, rd_vld;
  logic        push, pop, push_ok;
  entry_t      push_ent, head;
  entry_t      mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        full, empty, busy;

  logic        ovf;
  logic        ctrl_raw;
  logic        irq_bit;
  logic [31:0] stat_word, ctrl_word, rdata;

  state_t             state;
  logic [TW-1:0]      tmr;
  logic               lo_pend;
  logic               long_gap;
  logic [3:0]         lo_nib;
  logic [LCD_DW-1:0]  lcd_dat;
  logic               lcd_rs, lcd_e;
  logic [LCD_DW-1:0]  first_dat, second_dat;

  logic unused_bits;
  assign unused_bits = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:8]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_vld  <= 1'b0;
      ap_wr   <= 1'b0;
      ap_addr <= 2'd0;
    end else if (ahb.HREADY) begin
      ap_vld  <= ahb.HSEL & ahb.HTRANS[1];
      ap_wr   <= ahb.HWRITE;
      ap_addr <= ahb.HADDR[3:2];
    end
  end

  assign wr_cmd  = ap_vld & ap_wr & (ap_addr == 2'd0);
  assign wr_dat  = ap_vld & ap_wr & (ap_addr == 2'd1);
  assign wr_stat = ap_vld & ap_wr & (ap_addr == 2'd2);
  assign wr_ctrl = ap_vld & ap_wr & (ap_addr == 2'd3);
  assign rd_vld  = ap_vld & ~ap_wr;

  // Raw single-nibble mode only means something on a 4-bit bus.
  assign push_ent.rs  = wr_dat;
  assign push_ent.raw = ctrl_raw & (LCD_DW == 4);
  assign push_ent.dat = ahb.HWDATA[7:0];

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push    = wr_cmd | wr_dat;
  assign pop     = (state == S_IDLE) & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = push & (~full | pop);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign busy    = (state != S_IDLE) | ~empty;

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf <= 1'b0;
    end else if (push & full & ~pop) begin
      ovf <= 1'b1;
    end else if (wr_stat & ahb.HWDATA[3]) begin
      ovf <= 1'b0;
    end
  end

`ifdef LCD_IRQ_EN
  logic ctrl_irq_en;
  logic lcd_irq;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_raw    <= 1'b0;
      ctrl_irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_raw    <= ahb.HWDATA[1];
      ctrl_irq_en <= ahb.HWDATA[0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) lcd_irq <= 1'b0;
    else          lcd_irq <= ctrl_irq_en & empty & (state == S_IDLE);
  end

  assign irq_bit = ctrl_irq_en;
  assign LCD_IRQ = lcd_irq;
`else
  logic unused_irq_wdata;
  assign unused_irq_wdata = ahb.HWDATA[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     ctrl_raw <= 1'b0;
    else if (wr_ctrl) ctrl_raw <= ahb.HWDATA[1];
  end

  assign irq_bit = 1'b0;
`endif

  assign stat_word = {16'h0, 8'(level), 4'h0, ovf, empty, full, busy};
  assign ctrl_word = {30'h0, ctrl_raw, irq_bit};

  always_comb begin
    rdata = 32'h0;
    if (rd_vld) begin
      case (ap_addr)
        2'd2:    rdata = stat_word;
        2'd3:    rdata = ctrl_word;
        default: rdata = 32'h0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;

  generate
    if (LCD_DW == 8) begin : g_dw8
      assign first_dat  = head.dat;
      assign second_dat = {4'h0, lo_nib};
    end else begin : g_dw4
      assign first_dat  = head.raw ? head.dat[3:0] : head.dat[7:4];
      assign second_dat = lo_nib;
    end
  endgenerate

  // Strobe engine; reset clears E asynchronously even mid-pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      tmr      <= '0;
      lo_pend  <= 1'b0;
      long_gap <= 1'b0;
      lo_nib   <= 4'h0;
      lcd_dat  <= '0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            lcd_rs   <= head.rs;
            lcd_dat  <= first_dat;
            lo_nib   <= head.dat[3:0];
            lo_pend  <= (LCD_DW == 4) && !head.raw;
            long_gap <= !head.rs && (head.dat inside {8'h01, 8'h02, 8'h03});
            tmr      <= T_SETUP;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr == '0) begin
            lcd_e <= 1'b1;
            tmr   <= T_EHIGH;
            state <= S_EHIGH;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_EHIGH: begin
          if (tmr == '0) begin
            lcd_e <= 1'b0;
            tmr   <= T_HOLD;
            state <= S_HOLD;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_HOLD: begin
          if (tmr == '0) begin
            if (lo_pend) begin
              lo_pend <= 1'b0;
              lcd_dat <= second_dat;
              tmr     <= T_SETUP;
              state   <= S_SETUP;
            end else begin
              tmr   <= long_gap ? T_LONG : T_GAP;
              state <= S_GAP;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_GAP: begin
          if (tmr == '0) state <= S_IDLE;
          else           tmr   <= tmr - TW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign LCD_DATA = lcd_dat;
  assign LCD_RS   = lcd_rs;
  assign LCD_E    = lcd_e;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_ahb_lcd_fifo_ctrl.sv
// Bench for ahb_lcd_fifo_ctrl: register table, strobe scoreboard, and timing/overflow/reset sequences.
module tb_ahb_lcd_fifo_ctrl;
  localparam int DW = 4;
  localparam int DEPTH = 4;
  localparam int S = 3;
  localparam int EH = 4;
  localparam int H = 2;
  localparam int G = 10;
  localparam int L = 40;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [DW-1:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_e;
`ifdef LCD_IRQ_EN
  logic lcd_irq;
  localparam logic [31:0] CTRL_ALL = 32'h3;
  localparam logic [31:0] CTRL_IRQ = 32'h1;
`else
  localparam logic [31:0] CTRL_ALL = 32'h2;
  localparam logic [31:0] CTRL_IRQ = 32'h0;
`endif

  ahb_lcd_fifo_ctrl_if ahb ();
  assign ahb.HREADY = ahb.HREADYOUT;

  ahb_lcd_fifo_ctrl #(
    .LCD_DW(DW), .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .E_HIGH_CYC(EH),
    .HOLD_CYC(H), .GAP_CYC(G), .LONG_CYC(L)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(ahb),
    .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e)
`ifdef LCD_IRQ_EN
    , .LCD_IRQ(lcd_irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic          rs;
    logic [DW-1:0] dat;
  } strobe_t;

  strobe_t exp_q[$];
  int rise_log[$];
  int fall_log[$];
  int strobe_cnt = 0;
  int hi_cnt = 0;
  logic e_prev = 1'b0;

  // Scoreboard monitor: each E rise consumes one expected strobe.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      e_prev = 1'b0;
    end else begin
      if (lcd_e && !e_prev) begin
        rise_log.push_back(cyc);
        strobe_cnt++;
        hi_cnt = 1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: rs=%0b data=0x%0h, want no strobe", lcd_rs, lcd_data);
        end else begin
          strobe_t e;
          e = exp_q.pop_front();
          check("strobe_rs", 32'(lcd_rs), 32'(e.rs));
          check("strobe_dat", 32'(lcd_data), 32'(e.dat));
        end
      end else if (lcd_e && e_prev) begin
        hi_cnt++;
      end else if (!lcd_e && e_prev) begin
        fall_log.push_back(cyc);
        check("e_width", hi_cnt, EH);
      end
      e_prev = lcd_e;
    end
  end

  int last_wr_cyc = 0;

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    ahb.HSEL = 1'b1; ahb.HADDR = a; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1;
    @(posedge HCLK); #1;
    last_wr_cyc = cyc;
    ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0; ahb.HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    ahb.HSEL = 1'b1; ahb.HADDR = a; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b0;
    @(posedge HCLK); #1;
    ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00;
    d = ahb.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    logic [31:0] s;
    int n = 0;
    do begin
      ahb_read(32'h8, s);
      n++;
    end while (s[0] && n < budget);
    check(nm, 32'(s[0]), 32'h0);
  endtask

  task automatic wait_falls(input string nm, input int target, input int budget);
    int n = 0;
    while (fall_log.size() < target && n < budget) begin
      @(negedge HCLK); #1;
      n++;
    end
    check(nm, 32'(fall_log.size() >= target), 32'h1);
  endtask

  task automatic wait_rises(input string nm, input int target, input int budget);
    int n = 0;
    while (rise_log.size() < target && n < budget) begin
      @(negedge HCLK); #1;
      n++;
    end
    check(nm, 32'(rise_log.size() >= target), 32'h1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int b, c0;

    vecs[0] = '{1'b0, 32'h8, 32'h0,        32'h4,    "stat_reset"};
    vecs[1] = '{1'b0, 32'hC, 32'h0,        32'h0,    "ctrl_reset"};
    vecs[2] = '{1'b1, 32'hC, 32'hFFFFFFFF, 32'h0,    ""};
    vecs[3] = '{1'b0, 32'hC, 32'h0,        CTRL_ALL, "ctrl_all_ones"};
    vecs[4] = '{1'b1, 32'hC, 32'h1,        32'h0,    ""};
    vecs[5] = '{1'b0, 32'hC, 32'h0,        CTRL_IRQ, "ctrl_bit0"};
    vecs[6] = '{1'b1, 32'hC, 32'h0,        32'h0,    ""};
    vecs[7] = '{1'b0, 32'h0, 32'h0,        32'h0,    "cmd_reads_0"};
    vecs[8] = '{1'b0, 32'h4, 32'h0,        32'h0,    "data_reads_0"};
    vecs[9] = '{1'b0, 32'h8, 32'h0,        32'h4,    "stat_idle"};

    ahb.HSEL = 1'b0; ahb.HADDR = '0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0; ahb.HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // T1 reset state
    check("lcd_outputs_reset", 32'({lcd_e, lcd_rs, lcd_rw, lcd_data}), 32'h0);
    check("hreadyout", 32'(ahb.HREADYOUT), 32'h1);
    foreach (vecs[i]) begin
      if (vecs[i].wr) ahb_write(vecs[i].addr, vecs[i].wdata);
      else begin
        ahb_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].exp);
      end
    end

    // T2 4-bit byte split, high nibble first
    b = fall_log.size();
    exp_q.push_back('{1'b1, 4'h4});
    exp_q.push_back('{1'b1, 4'h1});
    ahb_write(32'h4, 32'h41);
    ahb_read(32'h8, rd);
    check("t2_busy_start", rd, 32'h5);
    wait_falls("t2_two_strobes", b + 2, 200);
    check("t2_nibble_spacing", rise_log[b + 1] - fall_log[b], H + S);
    ahb_read(32'h8, rd);
    check("t2_busy_in_gap", rd, 32'h5);
    repeat (G + H) @(posedge HCLK);
    #1;
    ahb_read(32'h8, rd);
    check("t2_idle_after_gap", rd, 32'h4);

    // T3 raw command nibble and write-to-E latency
    b = rise_log.size();
    c0 = strobe_cnt;
    ahb_write(32'hC, 32'h2);
    exp_q.push_back('{1'b0, 4'h3});
    ahb_write(32'h0, 32'h3);
    c0 = last_wr_cyc;
    wait_rises("t3_strobe", b + 1, 100);
    check("t3_latency", rise_log[b] - c0, 2 + S);
    wait_idle("t3_idle", 200);
    check("t3_single_strobe", rise_log.size() - b, 1);

    // T4 overflow: DEPTH+2 posted writes, first goes straight to the engine
    ahb_write(32'hC, 32'h0);
    for (int k = 0; k < DEPTH + 2; k++) begin
      logic [7:0] by;
      by = {4'(k + 1), 4'(9 - k)};
      if (k <= DEPTH) begin
        exp_q.push_back('{1'b1, by[7:4]});
        exp_q.push_back('{1'b1, by[3:0]});
      end
      ahb_write(32'h4, {24'h0, by});
    end
    ahb_read(32'h8, rd);
    check("t4_full_ovf", rd, 32'h40B);
    ahb_write(32'h8, 32'h8);
    ahb_read(32'h8, rd);
    check("t4_ovf_cleared", rd, 32'h403);
    wait_idle("t4_idle", 1000);
    check("t4_queue_drained", exp_q.size(), 0);

    // T5 clear-display command gets the long gap
    b = fall_log.size();
    exp_q.push_back('{1'b0, 4'h0});
    exp_q.push_back('{1'b0, 4'h1});
    exp_q.push_back('{1'b1, 4'h2});
    exp_q.push_back('{1'b1, 4'h0});
    ahb_write(32'h0, 32'h01);
    ahb_write(32'h4, 32'h20);
    wait_falls("t5_four_strobes", b + 4, 600);
    check("t5_nibble_gap", rise_log[b + 1] - fall_log[b], H + S);
    // One IDLE cycle sits between GAP and the next SETUP.
    check("t5_long_gap", rise_log[b + 2] - fall_log[b + 1], H + L + 1 + S);
    check("t5_short_next", rise_log[b + 3] - fall_log[b + 2], H + S);
    wait_idle("t5_idle", 200);

    // T6 reset in the middle of an E pulse
    b = rise_log.size();
    ahb_write(32'hC, 32'h2);
    exp_q.push_back('{1'b1, 4'hA});
    ahb_write(32'h4, 32'h5A);
    wait_rises("t6_strobe", b + 1, 100);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    check("t6_e_async_low", 32'(lcd_e), 32'h0);
    check("t6_outputs_zero", 32'({lcd_rs, lcd_data}), 32'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    c0 = strobe_cnt;
    repeat (L + G + 40) @(posedge HCLK);
    #1;
    check("t6_no_strobes", strobe_cnt - c0, 0);
    ahb_read(32'h8, rd);
    check("t6_stat", rd, 32'h4);
    ahb_read(32'hC, rd);
    check("t6_ctrl", rd, 32'h0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
